// File: rtl/regfile_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_ctrl_pkg
// Description : Shared types and defaults for the register-file write path.
//               Holds the controller state encoding, the default data and
//               address widths, and the two-way round-robin pick function.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_ctrl_pkg;

    localparam int c_DEFAULT_W = 16;   // register file data width
    localparam int c_DEFAULT_M = 4;    // address width, 2**M entries

    // Controller phase: INIT clears every entry, RUN arbitrates requesters.
    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } wr_state_t;

    // Two-way round-robin pick. A lone request always wins; on a tie the
    // requester named by the pointer wins. Result is one-hot or zero.
    function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic ptr);
        logic [1:0] grant;
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = ptr ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
        return grant;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-way round-robin arbiter with a single pointer flop.
//               Grant is combinational from the requests and the pointer;
//               the pointer moves to the non-granted side after each grant.
// Ports       : clk       - clock
//               rst       - synchronous active-high reset (pointer -> 0)
//               i_req     - request vector, bit N = requester N
//               i_advance - allow the pointer to move this cycle
//               o_grant   - one-hot grant (or zero when nothing requested)
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
    import regfile_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    input  logic       i_advance,
    output logic [1:0] o_grant
);

    logic r_ptr;   // 0: requester 0 wins a tie, 1: requester 1 wins a tie

    assign o_grant = rr_pick(i_req, r_ptr);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= 1'b0;
        end else if (i_advance && (|o_grant)) begin
            // Grant is one-hot: granting 0 hands priority to 1 and vice versa.
            r_ptr <= o_grant[0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wr_arbiter
// Description : Write-port controller for a 2**M x W register file. After
//               reset it sweeps every entry to zero, then arbitrates two
//               write requesters round-robin onto a single registered write
//               port (latency 1 from handshake to wen/wad/wdata).
// Ports       : clk                  - clock
//               reset                - synchronous active-high reset
//               req{0,1}_valid       - requester has a write pending
//               req{0,1}_addr[M-1:0] - requested write address
//               req{0,1}_data[W-1:0] - requested write data
//               req{0,1}_ready       - request accepted this cycle (comb.)
//               wen                  - registered write enable
//               wad[M-1:0]           - registered write address
//               wdata[W-1:0]         - registered write data
//               init_done            - clear sweep finished, arbitration live
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wr_arbiter
    import regfile_ctrl_pkg::*;
#(
    parameter int W = c_DEFAULT_W,
    parameter int M = c_DEFAULT_M
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0_valid,
    input  logic [M-1:0] req0_addr,
    input  logic [W-1:0] req0_data,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [M-1:0] req1_addr,
    input  logic [W-1:0] req1_data,
    output logic         req1_ready,
    output logic         wen,
    output logic [M-1:0] wad,
    output logic [W-1:0] wdata,
    output logic         init_done
);

    localparam logic [M-1:0] c_SWEEP_LAST = '1;

    wr_state_t    r_state;
    logic [M-1:0] r_sweep;
    logic         r_wen;
    logic [M-1:0] r_wad;
    logic [W-1:0] r_wdata;
    logic         r_init_done;

    logic         w_run;
    logic [1:0]   w_req;
    logic [1:0]   w_grant;

    // Requests are masked outside RUN and during reset so that ready can
    // only come from the current cycle's valids and never fires while the
    // sweep owns the write port.
    assign w_run = (r_state == ST_RUN) && !reset;
    assign w_req = {req1_valid, req0_valid} & {2{w_run}};

    rr_arb2 u_arb (
        .clk       (clk),
        .rst       (reset),
        .i_req     (w_req),
        .i_advance (w_run),
        .o_grant   (w_grant)
    );

    assign req0_ready = w_grant[0];
    assign req1_ready = w_grant[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_INIT;
            r_sweep     <= '0;
            r_wen       <= 1'b0;
            r_wad       <= '0;
            r_wdata     <= '0;
            r_init_done <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_wen   <= 1'b1;
                    r_wad   <= r_sweep;
                    r_wdata <= '0;
                    r_sweep <= r_sweep + M'(1);
                    // The last clear write is registered on this edge, so
                    // arbitration may start on the very next cycle.
                    if (r_sweep == c_SWEEP_LAST) begin
                        r_state     <= ST_RUN;
                        r_init_done <= 1'b1;
                    end
                end
                ST_RUN: begin
                    r_wen <= |w_grant;
                    if (w_grant[1]) begin
                        r_wad   <= req1_addr;
                        r_wdata <= req1_data;
                    end else if (w_grant[0]) begin
                        r_wad   <= req0_addr;
                        r_wdata <= req0_data;
                    end
                end
                default: begin
                    r_state <= ST_INIT;
                end
            endcase
        end
    end

    assign wen       = r_wen;
    assign wad       = r_wad;
    assign wdata     = r_wdata;
    assign init_done = r_init_done;

    // A requester left waiting must present the same write until accepted.
    a_req0_hold : assert property (@(posedge clk) disable iff (reset)
        (req0_valid && !req0_ready) |=> (req0_valid && $stable(req0_addr) && $stable(req0_data)));
    a_req1_hold : assert property (@(posedge clk) disable iff (reset)
        (req1_valid && !req1_ready) |=> (req1_valid && $stable(req1_addr) && $stable(req1_data)));
    a_ready_onehot : assert property (@(posedge clk) !(req0_ready && req1_ready));

endmodule
`default_nettype wire

// File: tb/tb_regfile_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wr_arbiter
// Description : Self-checking bench for regfile_wr_arbiter. Directed cases
//               for sweep, single request, contention, same-address
//               collision and mid-run reset, followed by random traffic
//               compared cycle by cycle against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wr_arbiter;

    localparam int W = 16;
    localparam int M = 4;
    localparam int N = 1 << M;

    logic         clk;
    logic         reset;
    logic         req0_valid, req1_valid;
    logic [M-1:0] req0_addr,  req1_addr;
    logic [W-1:0] req0_data,  req1_data;
    logic         req0_ready, req1_ready;
    logic         wen;
    logic [M-1:0] wad;
    logic [W-1:0] wdata;
    logic         init_done;

    regfile_wr_arbiter #(.W(W), .M(M)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .wen        (wen),
        .wad        (wad),
        .wdata      (wdata),
        .init_done  (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state
    bit           m_run;        // controller is arbitrating this cycle
    int           m_sweep;      // next address the clear sweep writes
    int           m_prio;       // requester that wins a tie
    bit           e_wen;        // expected registered outputs for next cycle
    logic [M-1:0] e_wad;
    logic [W-1:0] e_wdata;
    bit           e_chk_addr;
    bit           pend0, pend1; // stimulus must hold an un-accepted request
    logic [W-1:0] ref_mem [N];  // register file contents implied by the rules
    logic [W-1:0] dut_mem [N];  // register file built from the DUT write port

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    // One clock cycle: check last cycle's registered write, apply inputs,
    // check readies, then advance the model.
    task automatic step(input bit rst_in,
                        input bit n0, input logic [M-1:0] a0, input logic [W-1:0] d0,
                        input bit n1, input logic [M-1:0] a1, input logic [W-1:0] d1);
        bit g0, g1;
        @(posedge clk);
        #1;
        chk("wen", {31'b0, wen}, {31'b0, e_wen});
        if (e_wen || e_chk_addr) begin
            chk("wad",   {28'b0, wad}, {28'b0, e_wad});
            chk("wdata", {16'b0, wdata}, {16'b0, e_wdata});
        end
        if (wen === 1'b1) dut_mem[wad] = wdata;
        chk("init_done", {31'b0, init_done}, {31'b0, m_run});

        reset = rst_in;
        if (!pend0) begin
            req0_valid = n0; req0_addr = a0; req0_data = d0;
        end
        if (!pend1) begin
            req1_valid = n1; req1_addr = a1; req1_data = d1;
        end
        #1;

        g0 = 1'b0;
        g1 = 1'b0;
        if (!rst_in && m_run) begin
            if (req0_valid && req1_valid) begin
                if (m_prio == 0) g0 = 1'b1; else g1 = 1'b1;
            end else begin
                g0 = req0_valid;
                g1 = req1_valid;
            end
        end
        chk("req0_ready", {31'b0, req0_ready}, {31'b0, g0});
        chk("req1_ready", {31'b0, req1_ready}, {31'b0, g1});

        e_chk_addr = 1'b0;
        if (rst_in) begin
            e_wen = 1'b0; e_wad = '0; e_wdata = '0; e_chk_addr = 1'b1;
            m_run = 1'b0; m_sweep = 0; m_prio = 0;
        end else if (!m_run) begin
            e_wen = 1'b1; e_wad = M'(m_sweep); e_wdata = '0;
            ref_mem[m_sweep] = '0;
            m_sweep++;
            if (m_sweep == N) m_run = 1'b1;
        end else begin
            e_wen = g0 | g1;
            if (g0) begin
                e_wad = req0_addr; e_wdata = req0_data; ref_mem[req0_addr] = req0_data;
                m_prio = 1;
            end else if (g1) begin
                e_wad = req1_addr; e_wdata = req1_data; ref_mem[req1_addr] = req1_data;
                m_prio = 0;
            end
        end
        pend0 = req0_valid && !g0;
        pend1 = req1_valid && !g1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    initial begin
        reset = 1'b1;
        req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
        req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
        pend0 = 1'b0; pend1 = 1'b0;
        m_run = 1'b0; m_sweep = 0; m_prio = 0;
        e_wen = 1'b0; e_wad = '0; e_wdata = '0; e_chk_addr = 1'b1;
        for (int i = 0; i < N; i++) begin
            ref_mem[i] = '0;
            dut_mem[i] = '0;
        end
        @(posedge clk);

        // Reset state, then the full clear sweep.
        step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
        step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
        idle(N + 1);

        // Single requester.
        step(1'b0, 1'b1, 4'd5, 16'hABCD, 1'b0, '0, '0);
        idle(2);

        // Continuous contention.
        for (int i = 0; i < 6; i++)
            step(1'b0, 1'b1, M'($urandom_range(0, N - 1)), W'($urandom),
                       1'b1, M'($urandom_range(0, N - 1)), W'($urandom));
        idle(2);

        // Transfer, reset right after it, and both requesters colliding on
        // address 3 while held through the whole sweep.
        step(1'b0, 1'b1, 4'd7, 16'h7777, 1'b0, '0, '0);
        step(1'b1, 1'b1, 4'd3, 16'h1111, 1'b1, 4'd3, 16'h2222);
        idle(N + 3);
        chk("collision_entry3", {16'b0, dut_mem[3]}, 32'h0000_2222);

        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            logic [M-1:0] a0, a1;
            a0 = M'($urandom_range(0, N - 1));
            a1 = ($urandom_range(0, 3) == 0) ? a0 : M'($urandom_range(0, N - 1));
            step(($urandom_range(0, 149) == 0),
                 1'($urandom_range(0, 1)), a0, W'($urandom),
                 1'($urandom_range(0, 1)), a1, W'($urandom));
        end
        idle(N + 4);

        for (int i = 0; i < N; i++)
            chk("mem_final", {16'b0, dut_mem[i]}, {16'b0, ref_mem[i]});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_wr_arbiter.md
REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

Interface
REQ-001 SHALL have parameter W, default 16: data width, equal to the register file data width.
REQ-002 SHALL have parameter M, default 4: address width; the register file holds 2**M entries.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have ports req0_valid / req1_valid, input, 1: requester N has a write pending.
REQ-006 SHALL have ports req0_addr / req1_addr, input, M: target address.
REQ-007 SHALL have ports req0_data / req1_data, input, W: write data.
REQ-008 SHALL have ports req0_ready / req1_ready, output, 1: the request is accepted this cycle (combinational).
REQ-009 SHALL have port wen, output, 1: registered write enable to the register file.
REQ-010 SHALL have port wad, output, M: registered write address.
REQ-011 SHALL have port wdata, output, W: registered write data.
REQ-012 SHALL have port init_done, output, 1: the clear sweep is finished and arbitration is active.

Function
REQ-013 SHALL implement states INIT and RUN; reset forces INIT.
REQ-014 In INIT, SHALL drive reqN_ready=0 and register wen=1, wad=sweep counter, wdata=0 each cycle. The counter runs 0..2**M-1.
REQ-015 After the write at address 2**M-1 is registered, SHALL go to RUN. init_done SHALL read 1 from the next cycle onward.
REQ-016 In RUN, a transfer on requester N occurs when reqN_valid=1 and reqN_ready=1 in the same cycle.
REQ-017 In RUN with exactly one valid, SHALL assert that requester's ready.
REQ-018 In RUN with both valid, SHALL grant the requester holding the priority pointer; the other ready SHALL be 0.
REQ-019 Priority pointer SHALL move to the other requester after each grant and hold when no grant occurs.
REQ-020 At most one ready SHALL be high per cycle. Ready SHALL never depend on a prior-cycle valid.
REQ-021 The accepted addr/data SHALL appear on wad/wdata with wen=1 exactly one cycle after the transfer (latency 1).
REQ-022 A cycle with no transfer SHALL yield wen=0 the following cycle; wad/wdata are don't-care while wen=0.
REQ-023 Simultaneous requests to the same address SHALL be serialised in grant order; the later grant's data is the final value.
REQ-024 A requester that is not granted SHALL keep its valid/addr/data stable until granted. This is a requester obligation, checked by an assertion.

Reset
REQ-025 On a cycle with reset=1: state=INIT, sweep counter=0, pointer=requester 0, wen=0, wad=0, wdata=0, init_done=0, both readies 0.
REQ-026 In the first cycle after reset deasserts, SHALL register the first sweep write (wad=0). wen=1 SHALL therefore be visible in the second cycle.
REQ-027 Reset during INIT or RUN SHALL abandon the sweep or drop any registered-but-unperformed write (wen=0), then restart the full sweep.

Structure
REQ-028 SHALL place the state enum typedef (INIT, RUN) and default W/M constants in shared package regfile_ctrl_pkg.
REQ-029 SHALL contain one sub-module rr_arb2: a 2-way round-robin arbiter with req[1:0] and an advance enable in, and grant[1:0] out, holding the pointer flop.
REQ-030 The write port SHALL connect directly to the gated write-enable and decoder of the register file. No additional storage SHALL be inside this block.

Verification
REQ-031 Clear sweep (M=4): release reset -> wen=1 for 16 consecutive cycles with wad 0..15 and wdata 0, then init_done=1 and readies allowed.
REQ-032 Single requester: req0 valid, addr 5, data 0xABCD, in RUN -> req0_ready=1 same cycle; next cycle wen=1, wad=5, wdata=0xABCD.
REQ-033 Contention: both valid continuously, pointer=0 -> grants 0,1,0,1 on successive cycles; wen stays high every cycle.
REQ-034 Same-address collision: req0 writes 0x1111 and req1 writes 0x2222 to addr 3 -> two writes in grant order; readback of entry 3 = 0x2222 when req1 is granted second.
REQ-035 Reset mid-operation: assert reset in the cycle after a transfer -> wen=0 next cycle; the full 16-cycle sweep repeats and the pointer returns to requester 0.
REQ-036 Requests during INIT: req1 held valid from reset release -> req1_ready=0 for all 16 sweep cycles, then granted in the first RUN cycle.
